// File: rtl/wt_store_wbuf.sv
// ---------------------------------------------------------------------------
// wt_store_wbuf
//
// Write-through store buffer between the store unit and the data-memory
// write port. Committed word stores are queued in a circular buffer, issued
// to memory in order with a transaction ID, and retired in order once every
// older entry has been acknowledged. A word-address hazard check is provided
// to the load unit.
//
// Optional feature: define WT_STORE_WBUF_MERGE_EN to merge byte enables of an
// incoming store into the youngest entry that has not been issued yet.
//
// Parameters:
//   DEPTH  entry count (power of two, >= 2)
//   TID_W  transaction-ID width, at most 2**TID_W stores in flight
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      store request handshake
//   req_addr_i, req_data_i,
//   req_be_i, req_nc_i             store payload (addr[1:0] ignored)
//   mem_valid_o / mem_ready_i      memory write request handshake
//   mem_addr_o, mem_data_o,
//   mem_be_o, mem_tid_o            memory write payload
//   rsp_valid_i, rsp_tid_i         write acknowledgement
//   ld_addr_i, ld_hit_o            load hazard check (VALID/SENT entries)
//   empty_o, full_o                occupancy status
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once mem_valid_o rises it stays high with stable address, data,
// byte enables and tid until mem_ready_i is seen (a merge may still add bytes
// to a presented-but-unaccepted entry). req_ready_o never depends on
// req_valid_i.
// ---------------------------------------------------------------------------
module wt_store_wbuf #(
    parameter int DEPTH = 8,
    parameter int TID_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_data_i,
    input  logic [3:0]       req_be_i,
    input  logic             req_nc_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic [3:0]       mem_be_o,
    output logic [TID_W-1:0] mem_tid_o,
    input  logic             rsp_valid_i,
    input  logic [TID_W-1:0] rsp_tid_i,
    input  logic [31:0]      ld_addr_i,
    output logic             ld_hit_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NT = 1 << TID_W;

    typedef enum logic [1:0] {
        E_FREE  = 2'd0,
        E_VALID = 2'd1,
        E_SENT  = 2'd2,
        E_ACKED = 2'd3
    } entry_state_e;

    entry_state_e      st_q   [DEPTH];
    logic [29:0]       addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [TID_W-1:0]  tid_q  [DEPTH];

    logic [PW-1:0]     wr_ptr_q, iss_ptr_q, ret_ptr_q;
    logic [CW-1:0]     count_q;
    logic [NT-1:0]     tid_free_q, tid_free_d;
    // Tid captured while a request waits for mem_ready_i, so that a lower
    // tid freed in the meantime cannot change mem_tid_o mid-request.
    logic              hold_q;
    logic [TID_W-1:0]  hold_tid_q;

    logic [TID_W-1:0]  free_tid, iss_tid;
    logic              tid_avail, issue_fire, retire, accept, alloc, do_merge, merge_ok;

    // Lowest-numbered free tid.
    always_comb begin
        free_tid = '0;
        for (int t = NT - 1; t >= 0; t--) begin
            if (tid_free_q[t]) free_tid = TID_W'(t);
        end
    end

    assign tid_avail   = |tid_free_q;
    assign iss_tid     = hold_q ? hold_tid_q : free_tid;

    assign mem_valid_o = (st_q[iss_ptr_q] == E_VALID) && tid_avail;
    assign mem_addr_o  = {addr_q[iss_ptr_q], 2'b00};
    assign mem_data_o  = data_q[iss_ptr_q];
    assign mem_be_o    = be_q[iss_ptr_q];
    assign mem_tid_o   = iss_tid;
    assign issue_fire  = mem_valid_o && mem_ready_i;

    assign retire      = (st_q[ret_ptr_q] == E_ACKED);
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);

`ifdef WT_STORE_WBUF_MERGE_EN
    logic          nc_q [DEPTH];
    logic [PW-1:0] prev_ptr;

    assign prev_ptr = wr_ptr_q - PW'(1);
    // The youngest entry is still open for merging while it is VALID and not
    // leaving for memory on this very edge.
    assign merge_ok = (st_q[prev_ptr] == E_VALID) && !nc_q[prev_ptr] && !req_nc_i &&
                      (addr_q[prev_ptr] == req_addr_i[31:2]) &&
                      !(issue_fire && (iss_ptr_q == prev_ptr));
`else
    assign merge_ok = 1'b0;
`endif

    assign req_ready_o = !full_o || merge_ok;
    assign accept      = req_valid_i && req_ready_o;
    assign alloc       = accept && !merge_ok;
    assign do_merge    = accept && merge_ok;

    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((st_q[i] == E_VALID) || (st_q[i] == E_SENT)) &&
                (addr_q[i] == ld_addr_i[31:2])) ld_hit_o = 1'b1;
        end
    end

    // A response only frees a tid that is actually in flight.
    always_comb begin
        tid_free_d = tid_free_q;
        if (issue_fire) tid_free_d[iss_tid] = 1'b0;
        if (rsp_valid_i && !tid_free_q[rsp_tid_i]) tid_free_d[rsp_tid_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= E_FREE;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
                tid_q[i]  <= '0;
`ifdef WT_STORE_WBUF_MERGE_EN
                nc_q[i]   <= 1'b0;
`endif
            end
            wr_ptr_q   <= '0;
            iss_ptr_q  <= '0;
            ret_ptr_q  <= '0;
            count_q    <= '0;
            tid_free_q <= '1;
            hold_q     <= 1'b0;
            hold_tid_q <= '0;
        end else begin
            // Allocate, issue, ack and retire always touch distinct entries.
            if (alloc) begin
                st_q[wr_ptr_q]   <= E_VALID;
                addr_q[wr_ptr_q] <= req_addr_i[31:2];
                data_q[wr_ptr_q] <= req_data_i;
                be_q[wr_ptr_q]   <= req_be_i;
`ifdef WT_STORE_WBUF_MERGE_EN
                nc_q[wr_ptr_q]   <= req_nc_i;
`endif
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
`ifdef WT_STORE_WBUF_MERGE_EN
            if (do_merge) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_be_i[b]) data_q[prev_ptr][8*b +: 8] <= req_data_i[8*b +: 8];
                end
                be_q[prev_ptr] <= be_q[prev_ptr] | req_be_i;
            end
`endif
            if (issue_fire) begin
                st_q[iss_ptr_q]  <= E_SENT;
                tid_q[iss_ptr_q] <= iss_tid;
                iss_ptr_q        <= iss_ptr_q + PW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (rsp_valid_i && (st_q[i] == E_SENT) && (tid_q[i] == rsp_tid_i))
                    st_q[i] <= E_ACKED;
            end
            if (retire) begin
                st_q[ret_ptr_q] <= E_FREE;
                ret_ptr_q       <= ret_ptr_q + PW'(1);
            end
            count_q    <= count_q + CW'(alloc) - CW'(retire);
            tid_free_q <= tid_free_d;
            if (issue_fire) begin
                hold_q <= 1'b0;
            end else if (mem_valid_o) begin
                hold_q     <= 1'b1;
                hold_tid_q <= iss_tid;
            end
        end
    end

    // Low address bits are ignored; nc only matters when merging is built in.
    logic unused_bits;
    assign unused_bits = ^{req_addr_i[1:0], ld_addr_i[1:0], req_nc_i, do_merge};

`ifndef SYNTHESIS
    property p_rsp_in_flight;
        @(posedge clk_i) disable iff (!rst_ni) rsp_valid_i |-> !tid_free_q[rsp_tid_i];
    endproperty
    a_rsp_in_flight: assert property (p_rsp_in_flight)
        else $warning("wt_store_wbuf: ack for tid %0d not in flight, ignored", rsp_tid_i);
`endif

endmodule

// File: tb/tb_wt_store_wbuf.sv
// ---------------------------------------------------------------------------
// tb_wt_store_wbuf
//
// Directed bench for wt_store_wbuf (DEPTH=8, TID_W=2). Expected memory
// requests are queued by the stimulus; a monitor compares every accepted
// memory request against the head of that queue. Status outputs are checked
// directly at hand-computed cycles.
// ---------------------------------------------------------------------------
module tb_wt_store_wbuf;

    localparam int TID_W = 2;
    localparam int W     = 32 + 32 + 4 + TID_W;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_data_i;
    logic [3:0]       req_be_i;
    logic             req_nc_i;
    logic             mem_valid_o;
    logic             mem_ready_i;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_data_o;
    logic [3:0]       mem_be_o;
    logic [TID_W-1:0] mem_tid_o;
    logic             rsp_valid_i;
    logic [TID_W-1:0] rsp_tid_i;
    logic [31:0]      ld_addr_i;
    logic             ld_hit_o;
    logic             empty_o;
    logic             full_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp, mon_act;

    wt_store_wbuf #(.DEPTH(8), .TID_W(TID_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_be_i    (req_be_i),
        .req_nc_i    (req_nc_i),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_be_o    (mem_be_o),
        .mem_tid_o   (mem_tid_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_tid_i   (rsp_tid_i),
        .ld_addr_i   (ld_addr_i),
        .ld_hit_o    (ld_hit_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_i) begin
        if (rst_ni && mem_valid_o && mem_ready_i) begin
            checks++;
            mon_act = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_issue: got unexpected request 0x%h, required none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_issue: got 0x%h required 0x%h", mon_act, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] be, input logic [TID_W-1:0] tid);
        exp_q.push_back({a, d, be, tid});
    endfunction

    task automatic clear_req();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_data_i  = '0;
        req_be_i    = '0;
        req_nc_i    = 1'b0;
    endtask

    // Called in the post-edge phase; returns in the post-edge phase after the
    // edge at which the store was accepted.
    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic nc);
        int n;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        req_be_i    = be;
        req_nc_i    = nc;
        for (n = 0; n < 20; n++) begin
            sample();
            if (req_ready_o) break;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL store_accept: addr 0x%08h not accepted within 20 cycles", a);
        end
        tick();
        clear_req();
    endtask

    task automatic respond(input logic [TID_W-1:0] tid);
        rsp_valid_i = 1'b1;
        rsp_tid_i   = tid;
        tick();
        rsp_valid_i = 1'b0;
        rsp_tid_i   = '0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        clear_req();
        mem_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_tid_i   = '0;
        ld_addr_i   = '0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic check_drained(input string name);
        sample();
        check(name, exp_q.size(), 0);
        exp_q.delete();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_mem_valid"}, mem_valid_o, 0);
        check({tag, "_mem_addr"},  mem_addr_o, 0);
        check({tag, "_mem_data"},  mem_data_o, 0);
        check({tag, "_mem_be"},    mem_be_o, 0);
        check({tag, "_empty"},     empty_o, 1);
        check({tag, "_full"},      full_o, 0);
        check({tag, "_ld_hit"},    ld_hit_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_ni = 1'b0;
        apply_reset();

        // Reset values and a single store round trip.
        sample();
        check_reset_outputs("rst");
        tick();
        mem_ready_i = 1'b1;
        push_exp(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0004;
        req_data_i  = 32'hDEAD_BEEF;
        req_be_i    = 4'hF;
        sample();
        check("t1_no_bypass", mem_valid_o, 0);
        tick();
        clear_req();
        sample();
        check("t1_issue_valid", mem_valid_o, 1);
        check("t1_issue_tid", mem_tid_o, 0);
        tick();
        sample();
        check("t1_after_issue", mem_valid_o, 0);
        check("t1_not_empty", empty_o, 0);
        tick();
        respond(0);
        sample();
        check("t1_acked_not_retired", empty_o, 0);
        tick();
        sample();
        check("t1_empty_after_retire", empty_o, 1);
        check_drained("t1_drained");

        // Fill to full with memory stalled; ninth store must stall.
        apply_reset();
        for (int i = 0; i < 8; i++) store(32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 4'hF, 1'b0);
        sample();
        check("t2_full", full_o, 1);
        check("t2_ready_low", req_ready_o, 0);
        check("t2_not_empty", empty_o, 0);
        tick();
        req_valid_i = 1'b1;
        req_addr_i  = 32'h1020;
        req_data_i  = 32'h999;
        req_be_i    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t2_ninth_stalls", req_ready_o, 0);
            tick();
        end
        clear_req();
        ld_addr_i = 32'h1000;
        sample();
        check("t2_ld_hit_first", ld_hit_o, 1);
        tick();
        ld_addr_i = 32'h1003;
        sample();
        check("t2_ld_hit_same_word", ld_hit_o, 1);
        tick();
        ld_addr_i = 32'h1020;
        sample();
        check("t2_ld_miss", ld_hit_o, 0);
        tick();
        ld_addr_i = '0;
        check_drained("t2_drained");

        // Tid exhaustion: five stores, four in flight, fifth waits for a tid.
        apply_reset();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, TID_W'(i));
        push_exp(32'h2010, 32'hA4, 4'hF, 2);
        for (int i = 0; i < 5; i++) store(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0);
        tick();
        ld_addr_i = 32'h2010;
        sample();
        check("t3_fifth_held", mem_valid_o, 0);
        check("t3_fifth_ld_hit", ld_hit_o, 1);
        tick();
        ld_addr_i = '0;
        respond(2);
        sample();
        check("t3_fifth_valid", mem_valid_o, 1);
        check("t3_fifth_tid", mem_tid_o, 2);
        tick();
        sample();
        check("t3_fifth_gone", mem_valid_o, 0);
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h2100 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t3_no_retire_full", full_o, 1);
            tick();
        end
        check_drained("t3_drained");

        // Out-of-order acks 3,1,2,0: in-order retire, one per cycle.
        apply_reset();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(32'h3000 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, TID_W'(i));
        for (int i = 0; i < 4; i++) store(32'h3000 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, 1'b0);
        tick();
        respond(3);
        respond(1);
        respond(2);
        sample();
        check("t4_wait_oldest", empty_o, 0);
        tick();
        sample();
        check("t4_wait_oldest2", empty_o, 0);
        tick();
        respond(0);
        sample();
        check("t4_retire_c0", empty_o, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            sample();
            check("t4_retiring", empty_o, 0);
        end
        tick();
        sample();
        check("t4_empty_after_4", empty_o, 1);
        tick();
        check_drained("t4_drained");

        // Merge of two partial stores to the same word (cacheable).
        apply_reset();
        store(32'h100, 32'h0000_0011, 4'h1, 1'b0);
        store(32'h100, 32'h0000_2200, 4'h2, 1'b0);
`ifdef WT_STORE_WBUF_MERGE_EN
        push_exp(32'h100, 32'h0000_2211, 4'h3, 0);
        sample();
        check("t5_merged_be", mem_be_o, 4'h3);
        check("t5_merged_data", mem_data_o, 32'h0000_2211);
`else
        push_exp(32'h100, 32'h0000_0011, 4'h1, 0);
        push_exp(32'h100, 32'h0000_2200, 4'h2, 1);
        sample();
        check("t5_first_be", mem_be_o, 4'h1);
        check("t5_first_data", mem_data_o, 32'h0000_0011);
`endif
        tick();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        sample();
        check("t5_all_issued", mem_valid_o, 0);
        tick();
        check_drained("t5_drained");

        // Same pair with nc set never merges.
        apply_reset();
        store(32'h100, 32'h0000_0011, 4'h1, 1'b1);
        store(32'h100, 32'h0000_2200, 4'h2, 1'b1);
        push_exp(32'h100, 32'h0000_0011, 4'h1, 0);
        push_exp(32'h100, 32'h0000_2200, 4'h2, 1);
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_drained("t5nc_drained");

        // Reset with three entries in flight; late ack must be ignored.
        apply_reset();
        mem_ready_i = 1'b1;
        push_exp(32'h4000, 32'hD0, 4'hF, 0);
        push_exp(32'h4004, 32'hD1, 4'hF, 1);
        push_exp(32'h4008, 32'hD2, 4'hF, 2);
        store(32'h4001, 32'hD0, 4'hF, 1'b0);
        store(32'h4004, 32'hD1, 4'hF, 1'b0);
        store(32'h4008, 32'hD2, 4'hF, 1'b0);
        tick();
        ld_addr_i = 32'h4000;
        sample();
        check("t6_sent_ld_hit", ld_hit_o, 1);
        check("t6_sent_no_valid", mem_valid_o, 0);
        check("t6_sent_queue", exp_q.size(), 0);
        tick();
        rst_ni = 1'b0;
        sample();
        check_reset_outputs("t6_in_rst");
        tick();
        rst_ni = 1'b1;
        sample();
        check_reset_outputs("t6_after_rst");
        tick();
        respond(1);
        sample();
        check("t6_late_ack_empty", empty_o, 1);
        check("t6_late_ack_valid", mem_valid_o, 0);
        tick();
        ld_addr_i = '0;
        push_exp(32'h5000, 32'hE0, 4'hF, 0);
        store(32'h5000, 32'hE0, 4'hF, 1'b0);
        tick();
        tick();
        check_drained("t6_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wt_store_wbuf.md
# wt_store_wbuf

Write-through store buffer sitting between the CVA6 store unit and the data-memory port of a 32-bit, write-through-cache core configuration. Accepts committed word stores, optionally merges byte enables into the youngest unsent entry, issues entries in order to memory with a transaction ID, and retires them in order once every older entry is acknowledged. Also provides a word-address hazard check for the load unit.

## Interface
- DEPTH, 8: entry count (power of two, ≥2)
- TID_W, 2: transaction-ID width; at most 2^TID_W stores in flight
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  store request
- req_ready_o  out  1  store accepted when valid & ready
- req_addr_i  in  32  byte address; bits [1:0] ignored
- req_data_i  in  32  store data
- req_be_i  in  4  byte enables
- req_nc_i  in  1  non-cacheable / non-idempotent; never merged
- mem_valid_o  out  1  memory write request
- mem_ready_i  in  1  memory accepts request
- mem_addr_o  out  32  word address, [1:0]=0
- mem_data_o  out  32  write data
- mem_be_o  out  4  byte enables
- mem_tid_o  out  TID_W  transaction ID
- rsp_valid_i  in  1  write acknowledgement
- rsp_tid_i  in  TID_W  ID being acknowledged
- ld_addr_i  in  32  load address for hazard check
- ld_hit_o  out  1  a VALID or SENT entry matches ld_addr_i[31:2]
- empty_o  out  1  no occupied entries
- full_o  out  1  all DEPTH entries occupied

## Operation
- Circular buffer, three pointers: wr_ptr (allocate), iss_ptr (next to issue), ret_ptr (oldest); count register 0..DEPTH.
- Entry states: FREE → VALID (allocated) → SENT (issued, tid held) → ACKED (response seen) → FREE (retired).
- Allocate on req_valid_i & req_ready_o when not merged: entry at wr_ptr ← {addr[31:2], data, be, nc}, state VALID, wr_ptr++.
- Issue: mem_valid_o = entry[iss_ptr] is VALID and a free tid exists. On mem_valid_o & mem_ready_i: lowest-numbered free tid assigned, state SENT, iss_ptr++.
- Tid pool: 2^TID_W-bit free mask; tid cleared on issue, set on matching response.
- Response: SENT entry holding rsp_tid_i → ACKED; tid freed. Response for a tid not in flight is ignored (simulation assertion fires).
- Retire: if entry[ret_ptr] is ACKED → FREE, ret_ptr++, count--. At most one retire per cycle; out-of-order acks wait behind older entries.
- req_ready_o = !full_o, or merge possible (see Configuration).
- ld_hit_o combinational over VALID and SENT entries only.
- Pointers wrap modulo DEPTH; count disambiguates full vs empty.

## Timing
- Reset: all entries FREE, pointers 0, count 0, tid mask all free; req_ready_o=1, mem_valid_o=0, mem_* data 0, empty_o=1, full_o=0, ld_hit_o=0 (with no match).
- Store accepted at edge t → mem_valid_o earliest in cycle t+1 (no same-cycle bypass).
- mem_valid_o, once high, holds with stable addr/data/be/tid until mem_ready_i.
- Response at edge t → tid reusable for issue in cycle t+1; entry retires at edge t+1 if it is the oldest; slot visible to req_ready_o in cycle t+2.
- full_o/req_ready_o derive from registered count only: a retire and an allocate in the same cycle both occur; when full, no allocate even if retiring.
- Response and issue in same cycle on the same tid impossible (tid not free); response on another tid and issue proceed concurrently.
- Reset asserted mid-operation discards all entries and in-flight tids immediately; late responses after reset are ignored.

## Configuration
- WT_STORE_WBUF_MERGE_EN defined: an incoming store merges into entry[wr_ptr-1] if that entry is VALID, both nc flags 0, word addresses equal, and it is not being issued in the same cycle; bytes with req_be_i=1 overwrite data, be ← old be | req_be_i; no allocation. req_ready_o is also 1 when full and merge is possible.
- Undefined: every accepted store allocates a new entry; no merge logic.

## Test plan
- Reset, single store addr 0x8000_0004 data 0xDEAD_BEEF be 0xF, mem_ready_i=1 → mem_valid_o in cycle t+1, tid 0; rsp tid 0 → empty_o=1 two cycles later.
- 9 stores, mem_ready_i=0 → full_o after 8, req_ready_o=0, 9th stalls; ld_addr_i=first address → ld_hit_o=1.
- 5 stores issued, no responses → only 4 issued (tids 0-3), 5th holds mem_valid_o=0; rsp tid 2 → 5th issues with tid 2 next cycle; no retire until tid 0 acked.
- Out-of-order acks 3,1,2,0 → entries retire in order only after tid 0, one per cycle, empty_o=1 after four retire cycles.
- MERGE_EN: stores 0x100 be 0x1 data 0x11 then 0x100 be 0x2 data 0x2200, mem_ready_i=0 → one entry, be 0x3, data 0x0000_2211; same with req_nc_i=1 → two entries.
- Reset asserted with 3 entries SENT → all outputs at reset values next cycle; subsequent rsp_valid_i ignored.
